// File: rtl/lcd_bus_writer_if.sv
// CPU-side write port and 8080-style LCD write bus of lcd_bus_writer.
// The master drives the CPU store; the slave (the writer) owns status and bus pins.
interface lcd_bus_writer_if #(
    parameter int WIDTH = 18
);
    logic [1:0]       sel;
    logic             go;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] y;
    logic             full;
    logic [7:0]       lcd_d;
    logic             lcd_dcx;
    logic             lcd_wrx;
    logic             lcd_csx;

    modport master (
        output sel, go, a,
        input  y, full, lcd_d, lcd_dcx, lcd_wrx, lcd_csx
    );

    modport slave (
        input  sel, go, a,
        output y, full, lcd_d, lcd_dcx, lcd_wrx, lcd_csx
    );
endinterface

// File: rtl/lcd_bus_writer.sv
// Buffers CPU cmd/data/pixel stores in a small FIFO and strobes them onto an 8-bit LCD bus.
// Define LCD_RGB565_EN to send each pixel as two RGB565 bytes instead of three RGB666 bytes.
module lcd_bus_writer #(
    parameter int WIDTH      = 18,
    parameter int DEPTH_LOG2 = 2,
    parameter int WR_LOW     = 1,
    parameter int WR_HIGH    = 1
) (
    input logic             clk,
    input logic             rst_n,
    lcd_bus_writer_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = $clog2((WR_LOW > WR_HIGH) ? WR_LOW : WR_HIGH) + 1;
    localparam logic [DEPTH_LOG2:0]   DEPTH_C = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2 + 1)'(1);
    localparam logic [1:0] K_CMD = 2'd0;
    localparam logic [1:0] K_PIX = 2'd2;
`ifdef LCD_RGB565_EN
    localparam logic [1:0] PIX_LAST = 2'd1;
`else
    localparam logic [1:0] PIX_LAST = 2'd2;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_LOW, ST_HIGH} state_t;

    logic [19:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic [3:0]            status_q, status_d;

    state_t                state_q;
    logic [1:0]            bidx_q;
    logic [CW-1:0]         tcnt_q;
    logic [1:0]            kind_q;
    logic [17:0]           pay_q;
    logic [7:0]            lcd_d_q;
    logic                  lcd_dcx_q, lcd_wrx_q, lcd_csx_q;

    logic                  fifo_full, fifo_empty, push_req, push, pop, ctl_clear;
    logic                  low_done, high_done, last_byte, busy_d;
    logic [19:0]           head;
    logic [1:0]            head_kind;
    logic [17:0]           head_pay;
    logic [7:0]            head_byte;

    // Byte idx of an entry as it appears on the bus; cmd/data carry one byte in payload[7:0].
    function automatic logic [7:0] byte_sel(input logic [1:0] kind, input logic [17:0] p,
                                            input logic [1:0] idx);
        logic [7:0] b;
        b = p[7:0];
        if (kind == K_PIX) begin
`ifdef LCD_RGB565_EN
            b = (idx == 2'd0) ? {p[17:13], p[11:9]} : {p[8:6], p[5:1]};
`else
            case (idx)
                2'd0:    b = {p[17:12], 2'b00};
                2'd1:    b = {p[11:6], 2'b00};
                default: b = {p[5:0], 2'b00};
            endcase
`endif
        end
        return b;
    endfunction

    assign fifo_full  = (count_q == DEPTH_C);
    assign fifo_empty = (count_q == '0);
    assign push_req   = bus.go && (bus.sel != 2'd3);
    assign push       = push_req && !fifo_full;
    assign ctl_clear  = bus.go && (bus.sel == 2'd3) && bus.a[0];

    assign head      = mem_q[rd_ptr_q];
    assign head_kind = head[19:18];
    assign head_pay  = head[17:0];
    assign head_byte = byte_sel(head_kind, head_pay, 2'd0);

    assign low_done  = (tcnt_q == CW'(WR_LOW - 1));
    assign high_done = (tcnt_q == CW'(WR_HIGH - 1));
    assign last_byte = (kind_q != K_PIX) || (bidx_q == PIX_LAST);
    // A pop happens only when the serializer is ready to start a fresh entry.
    assign pop = !fifo_empty &&
                 ((state_q == ST_IDLE) || ((state_q == ST_HIGH) && high_done && last_byte));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (push_req && fifo_full) ovf_d = 1'b1;
        if (ctl_clear)             ovf_d = 1'b0;
    end

    // Busy after this edge: a pop always starts a transfer; otherwise only the last HIGH ends one.
    assign busy_d = (count_d != '0) || pop ||
                    ((state_q != ST_IDLE) && !((state_q == ST_HIGH) && high_done && last_byte));
    assign status_d = {ovf_d, busy_d, (count_d == DEPTH_C), (count_d == '0)};

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.sel, bus.a[17:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            status_q <= 4'b0001;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            status_q <= status_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bidx_q    <= 2'd0;
            tcnt_q    <= '0;
            kind_q    <= K_CMD;
            pay_q     <= '0;
            lcd_d_q   <= 8'h00;
            lcd_dcx_q <= 1'b1;
            lcd_wrx_q <= 1'b1;
            lcd_csx_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    lcd_wrx_q <= 1'b1;
                    if (pop) begin
                        kind_q    <= head_kind;
                        pay_q     <= head_pay;
                        bidx_q    <= 2'd0;
                        lcd_d_q   <= head_byte;
                        lcd_dcx_q <= (head_kind != K_CMD);
                        lcd_csx_q <= 1'b0;
                        state_q   <= ST_LOAD;
                    end else begin
                        lcd_csx_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    lcd_wrx_q <= 1'b0;
                    tcnt_q    <= '0;
                    state_q   <= ST_LOW;
                end
                ST_LOW: begin
                    if (low_done) begin
                        lcd_wrx_q <= 1'b1;
                        tcnt_q    <= '0;
                        state_q   <= ST_HIGH;
                    end else begin
                        tcnt_q <= tcnt_q + CW'(1);
                    end
                end
                ST_HIGH: begin
                    if (high_done) begin
                        tcnt_q <= '0;
                        if (!last_byte) begin
                            bidx_q  <= bidx_q + 2'd1;
                            lcd_d_q <= byte_sel(kind_q, pay_q, bidx_q + 2'd1);
                            state_q <= ST_LOAD;
                        end else if (pop) begin
                            // Chip select stays asserted across back-to-back entries.
                            kind_q    <= head_kind;
                            pay_q     <= head_pay;
                            bidx_q    <= 2'd0;
                            lcd_d_q   <= head_byte;
                            lcd_dcx_q <= (head_kind != K_CMD);
                            state_q   <= ST_LOAD;
                        end else begin
                            lcd_csx_q <= 1'b1;
                            state_q   <= ST_IDLE;
                        end
                    end else begin
                        tcnt_q <= tcnt_q + CW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.y       = {{(WIDTH - 4){1'b0}}, status_q};
    assign bus.full    = status_q[1];
    assign bus.lcd_d   = lcd_d_q;
    assign bus.lcd_dcx = lcd_dcx_q;
    assign bus.lcd_wrx = lcd_wrx_q;
    assign bus.lcd_csx = lcd_csx_q;
endmodule

// File: tb/tb_lcd_bus_writer.sv
// Directed self-checking bench for lcd_bus_writer: default-timing instance plus a slow-strobe instance.
module tb_lcd_bus_writer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

`ifdef LCD_RGB565_EN
    localparam int NB = 2;
`else
    localparam int NB = 3;
`endif

    lcd_bus_writer_if #(.WIDTH(18)) ifa ();
    lcd_bus_writer_if #(.WIDTH(18)) ifb ();

    lcd_bus_writer #(.WIDTH(18), .DEPTH_LOG2(2), .WR_LOW(1), .WR_HIGH(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
    );
    lcd_bus_writer #(.WIDTH(18), .DEPTH_LOG2(2), .WR_LOW(3), .WR_HIGH(2)) dut_slow (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave)
    );

    // Bytes latched by the LCD on each rising lcd_wrx: {dcx, data}.
    logic [8:0] bytes_q [$];
    logic       wrx_prev = 1'b1;
    always @(negedge clk) begin
        if (!rst_n) begin
            wrx_prev = 1'b1;
        end else begin
            if (!wrx_prev && ifa.lcd_wrx) bytes_q.push_back({ifa.lcd_dcx, ifa.lcd_d});
            wrx_prev = ifa.lcd_wrx;
        end
    end

    function automatic logic [7:0] pix_byte(input logic [17:0] p, input int idx);
`ifdef LCD_RGB565_EN
        if (idx == 0) return {p[17:13], p[11:9]};
        return {p[8:6], p[5:1]};
`else
        if (idx == 0) return {p[17:12], 2'b00};
        if (idx == 1) return {p[11:6], 2'b00};
        return {p[5:0], 2'b00};
`endif
    endfunction

    // Called at a negedge; go is sampled at the next posedge and the task returns one negedge later.
    task automatic cpu_write(input logic [1:0] s, input logic [17:0] d);
        ifa.sel = s; ifa.a = d; ifa.go = 1'b1;
        @(negedge clk);
        ifa.go = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (ifa.y[2] && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ifa.y[2]) begin
            errors++;
            $display("FAIL %s: busy still %0b after %0d cycles, required 0", name, ifa.y[2], n);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks += 5;
        if (ifa.y !== 18'h00001) begin errors++; $display("FAIL reset_y: got %h, required 00001", ifa.y); end
        if (ifa.lcd_csx !== 1'b1) begin errors++; $display("FAIL reset_csx: got %b, required 1", ifa.lcd_csx); end
        if (ifa.lcd_wrx !== 1'b1) begin errors++; $display("FAIL reset_wrx: got %b, required 1", ifa.lcd_wrx); end
        if (ifa.lcd_dcx !== 1'b1) begin errors++; $display("FAIL reset_dcx: got %b, required 1", ifa.lcd_dcx); end
        if (ifa.lcd_d !== 8'h00) begin errors++; $display("FAIL reset_d: got %h, required 00", ifa.lcd_d); end
        rst_n = 1'b1;
        @(negedge clk);
        checks += 2;
        if (ifa.y !== 18'h00001) begin errors++; $display("FAIL post_reset_y: got %h, required 00001", ifa.y); end
        if (ifa.full !== 1'b0) begin errors++; $display("FAIL post_reset_full: got %b, required 0", ifa.full); end
        $display("test_reset done");
    endtask

    task automatic test_cmd;
        bytes_q.delete();
        cpu_write(2'd0, 18'h0002C);
        checks += 2;
        if (ifa.lcd_csx !== 1'b1) begin errors++; $display("FAIL cmd_e0_csx: got %b, required 1", ifa.lcd_csx); end
        if (ifa.y !== 18'h00004) begin errors++; $display("FAIL cmd_e0_y: got %h, required 00004", ifa.y); end
        @(negedge clk);
        checks += 5;
        if (ifa.lcd_csx !== 1'b0) begin errors++; $display("FAIL cmd_e1_csx: got %b, required 0", ifa.lcd_csx); end
        if (ifa.lcd_dcx !== 1'b0) begin errors++; $display("FAIL cmd_e1_dcx: got %b, required 0", ifa.lcd_dcx); end
        if (ifa.lcd_d !== 8'h2C) begin errors++; $display("FAIL cmd_e1_d: got %h, required 2c", ifa.lcd_d); end
        if (ifa.lcd_wrx !== 1'b1) begin errors++; $display("FAIL cmd_e1_wrx: got %b, required 1", ifa.lcd_wrx); end
        if (ifa.y !== 18'h00005) begin errors++; $display("FAIL cmd_e1_y: got %h, required 00005", ifa.y); end
        @(negedge clk);
        checks++;
        if (ifa.lcd_wrx !== 1'b0) begin errors++; $display("FAIL cmd_e2_wrx: got %b, required 0", ifa.lcd_wrx); end
        @(negedge clk);
        checks += 2;
        if (ifa.lcd_wrx !== 1'b1) begin errors++; $display("FAIL cmd_e3_wrx: got %b, required 1", ifa.lcd_wrx); end
        if (ifa.lcd_csx !== 1'b0) begin errors++; $display("FAIL cmd_e3_csx: got %b, required 0", ifa.lcd_csx); end
        @(negedge clk);
        checks += 3;
        if (ifa.lcd_csx !== 1'b1) begin errors++; $display("FAIL cmd_e4_csx: got %b, required 1", ifa.lcd_csx); end
        if (ifa.y !== 18'h00001) begin errors++; $display("FAIL cmd_e4_y: got %h, required 00001", ifa.y); end
        if (bytes_q.size() != 1 || bytes_q[0] !== 9'h02C) begin
            errors++;
            $display("FAIL cmd_bytes: got %0d bytes first %h, required 1 byte 02c", bytes_q.size(),
                     (bytes_q.size() > 0) ? bytes_q[0] : 9'h1FF);
        end
        $display("test_cmd done");
    endtask

    task automatic test_pixel;
        logic [7:0] exp_b [3];
        int gaps;
`ifdef LCD_RGB565_EN
        exp_b = '{8'hF8, 8'h1F, 8'h00};
`else
        exp_b = '{8'hFC, 8'h00, 8'hFC};
`endif
        bytes_q.delete();
        gaps = 0;
        cpu_write(2'd2, 18'h3F03F);
        for (int k = 1; k <= 3 * NB + 1; k++) begin
            @(negedge clk);
            if (k <= 3 * NB && ifa.lcd_csx !== 1'b0) gaps++;
            if (k == 3 * NB + 1) begin
                checks++;
                if (ifa.lcd_csx !== 1'b1) begin errors++; $display("FAIL pix_end_csx: got %b, required 1", ifa.lcd_csx); end
            end
        end
        checks += 2;
        if (gaps != 0) begin errors++; $display("FAIL pix_csx_low: got %0d high cycles, required 0", gaps); end
        if (bytes_q.size() != NB) begin errors++; $display("FAIL pix_count: got %0d bytes, required %0d", bytes_q.size(), NB); end
        for (int i = 0; i < NB && i < bytes_q.size(); i++) begin
            checks++;
            if (bytes_q[i] !== {1'b1, exp_b[i]}) begin
                errors++;
                $display("FAIL pix_byte%0d: got %h, required %h", i, bytes_q[i], {1'b1, exp_b[i]});
            end
        end
        $display("test_pixel done");
    endtask

    task automatic test_overflow;
        logic [17:0] px [6];
        px = '{18'h3FFFF, 18'h12345, 18'h0ABCD, 18'h20F0F, 18'h15555, 18'h2AAAA};
        bytes_q.delete();
        for (int i = 0; i < 6; i++) cpu_write(2'd2, px[i]);
        checks += 2;
        if (ifa.y !== 18'h0000E) begin errors++; $display("FAIL ovf_y: got %h, required 0000e", ifa.y); end
        if (ifa.full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b, required 1", ifa.full); end
        wait_idle("ovf_drain");
        checks++;
        if (bytes_q.size() != 5 * NB) begin
            errors++;
            $display("FAIL ovf_count: got %0d bytes, required %0d", bytes_q.size(), 5 * NB);
        end
        for (int i = 0; i < 5 * NB && i < bytes_q.size(); i++) begin
            checks++;
            if (bytes_q[i] !== {1'b1, pix_byte(px[i / NB], i % NB)}) begin
                errors++;
                $display("FAIL ovf_byte%0d: got %h, required %h", i, bytes_q[i], {1'b1, pix_byte(px[i / NB], i % NB)});
            end
        end
        cpu_write(2'd3, 18'h00000);
        checks++;
        if (ifa.y !== 18'h00009) begin errors++; $display("FAIL ctl_noclear_y: got %h, required 00009", ifa.y); end
        cpu_write(2'd3, 18'h00001);
        checks++;
        if (ifa.y !== 18'h00001) begin errors++; $display("FAIL ctl_clear_y: got %h, required 00001", ifa.y); end
        $display("test_overflow done");
    endtask

    task automatic test_back_to_back;
        int highs;
        logic [8:0] exp_b [3];
        exp_b = '{9'h02A, 9'h100, 9'h1EF};
        bytes_q.delete();
        highs = 0;
        cpu_write(2'd0, 18'h0002A);
        cpu_write(2'd1, 18'h00000);
        cpu_write(2'd1, 18'h000EF);
        for (int n = 0; n < 200 && ifa.y[2]; n++) begin
            if (ifa.lcd_csx !== 1'b0) highs++;
            @(negedge clk);
        end
        checks += 3;
        if (ifa.y[2] !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy %b, required 0", ifa.y[2]); end
        if (highs != 0) begin errors++; $display("FAIL b2b_csx: got %0d high cycles, required 0", highs); end
        if (bytes_q.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d bytes, required 3", bytes_q.size()); end
        for (int i = 0; i < 3 && i < bytes_q.size(); i++) begin
            checks++;
            if (bytes_q[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL b2b_byte%0d: got %h, required %h", i, bytes_q[i], exp_b[i]);
            end
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid;
        int lows;
        cpu_write(2'd2, 18'h3F03F);
        cpu_write(2'd0, 18'h00011);
        repeat (4) @(negedge clk);
        checks++;
        if (ifa.lcd_wrx !== 1'b0) begin errors++; $display("FAIL midrst_pre_wrx: got %b, required 0", ifa.lcd_wrx); end
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (ifa.lcd_wrx !== 1'b1) begin errors++; $display("FAIL midrst_wrx: got %b, required 1", ifa.lcd_wrx); end
        if (ifa.lcd_csx !== 1'b1) begin errors++; $display("FAIL midrst_csx: got %b, required 1", ifa.lcd_csx); end
        if (ifa.y !== 18'h00001) begin errors++; $display("FAIL midrst_y: got %h, required 00001", ifa.y); end
        @(negedge clk);
        rst_n = 1'b1;
        bytes_q.delete();
        lows = 0;
        repeat (20) begin
            @(negedge clk);
            if (ifa.lcd_csx !== 1'b1) lows++;
        end
        checks += 2;
        if (lows != 0) begin errors++; $display("FAIL midrst_residual_csx: got %0d low cycles, required 0", lows); end
        if (bytes_q.size() != 0) begin errors++; $display("FAIL midrst_residual_bytes: got %0d, required 0", bytes_q.size()); end
        $display("test_reset_mid done");
    endtask

    task automatic test_slow_timing;
        int low_cnt, cs_cnt, bad_d, first_low, last_low;
        low_cnt = 0; cs_cnt = 0; bad_d = 0; first_low = -1; last_low = -1;
        ifb.sel = 2'd1; ifb.a = 18'h000A5; ifb.go = 1'b1;
        @(negedge clk);
        ifb.go = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (ifb.lcd_wrx === 1'b0) begin
                low_cnt++;
                if (first_low < 0) first_low = k;
                last_low = k;
            end
            if (ifb.lcd_csx === 1'b0) begin
                cs_cnt++;
                if (ifb.lcd_d !== 8'hA5 || ifb.lcd_dcx !== 1'b1) bad_d++;
            end
        end
        checks += 5;
        if (low_cnt != 3) begin errors++; $display("FAIL slow_wrx_low: got %0d cycles, required 3", low_cnt); end
        if (first_low != 2 || last_low != 4) begin
            errors++; $display("FAIL slow_wrx_window: got %0d..%0d, required 2..4", first_low, last_low);
        end
        if (cs_cnt != 6) begin errors++; $display("FAIL slow_period: got %0d cycles, required 6", cs_cnt); end
        if (bad_d != 0) begin errors++; $display("FAIL slow_d_stable: got %0d bad samples, required 0", bad_d); end
        if (ifb.lcd_csx !== 1'b1) begin errors++; $display("FAIL slow_end_csx: got %b, required 1", ifb.lcd_csx); end
        $display("test_slow_timing done");
    endtask

    initial begin
        ifa.sel = 2'd0; ifa.a = '0; ifa.go = 1'b0;
        ifb.sel = 2'd0; ifb.a = '0; ifb.go = 1'b0;
        test_reset();
        test_cmd();
        test_pixel();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_slow_timing();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
